// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use stall, taken-branch
// flush, and counted MULT/DIV freeze, plus a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_RegS,
    input  logic [4:0]       if_id_RegT,
    input  logic             if_id_UsesT,
    input  logic [4:0]       id_ex_RegT,
    input  logic             id_ex_MemRead,
    input  logic             branch_taken,
    input  logic             md_start,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_Hold,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic ifIdFlush;
        logic idExBubble;
        logic exHold;
        logic mdDone;
    } ctrl_t;

    // The RUN cycle that sees md_start is the first stalled cycle, so the
    // busy phase only has to cover the remaining MD_LATENCY-1 cycles.
    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

    state_t           state, stateNxt;
    logic [3:0]       mdCnt, mdCntNxt;
    ctrl_t            ctrl;
    logic             loadUse;
    logic [CNT_W-1:0] stallCnt;

    assign loadUse = id_ex_MemRead && (id_ex_RegT != 5'd0) &&
                     ((id_ex_RegT == if_id_RegS) ||
                      (if_id_UsesT && (id_ex_RegT == if_id_RegT)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            mdCnt <= 4'd0;
        end else begin
            state <= stateNxt;
            mdCnt <= mdCntNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        mdCntNxt = mdCnt;
        unique case (state)
            RUN: begin
                if (md_start) begin
                    stateNxt = MD_BUSY;
                    mdCntNxt = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (mdCnt == 4'd0) stateNxt = RUN;
                else               mdCntNxt = mdCnt - 4'd1;
            end
            default: stateNxt = RUN;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl.ifIdFlush  = 1'b1;
            ctrl.idExBubble = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    // md_start outranks hazards: its operands are frozen and
                    // load-use/branch get re-evaluated once EX drains.
                    if (md_start) begin
                        ctrl.exHold = 1'b1;
                    end else if (loadUse) begin
                        ctrl.idExBubble = 1'b1;
                    end else begin
                        ctrl.pcWrite   = 1'b1;
                        ctrl.ifIdWrite = 1'b1;
                        ctrl.ifIdFlush = branch_taken;
                    end
                end
                MD_BUSY: begin
                    ctrl.exHold = (mdCnt != 4'd0);
                    ctrl.mdDone = (mdCnt == 4'd0);
                end
                default: ctrl = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stallCnt <= '0;
        else if (!ctrl.pcWrite && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + CNT_W'(1);
    end

    assign PCWrite      = ctrl.pcWrite;
    assign IF_ID_Write  = ctrl.ifIdWrite;
    assign IF_ID_Flush  = ctrl.ifIdFlush;
    assign ID_EX_Bubble = ctrl.idExBubble;
    assign EX_Hold      = ctrl.exHold;
    assign md_done      = ctrl.mdDone;
    assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: RUN-state vector table plus
// hand-written reset, load-use, branch, MULT/DIV and saturation sequences.
module tb_hazard_stall_ctrl;

    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       if_id_RegS, if_id_RegT, id_ex_RegT;
    logic             if_id_UsesT, id_ex_MemRead, branch_taken, md_start;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, md_done;
    logic [CNT_W-1:0] stall_cycles;

    int nChecks = 0;
    int nFail   = 0;
    int doneCnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_id_RegS(if_id_RegS), .if_id_RegT(if_id_RegT), .if_id_UsesT(if_id_UsesT),
        .id_ex_RegT(id_ex_RegT), .id_ex_MemRead(id_ex_MemRead),
        .branch_taken(branch_taken), .md_start(md_start),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .EX_Hold(EX_Hold), .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    // exp = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold}
    typedef struct {
        logic [4:0] rs, rt;
        logic       usesT;
        logic [4:0] exRt;
        logic       memRd, br;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        if_id_RegS = 5'd0; if_id_RegT = 5'd0; if_id_UsesT = 1'b0;
        id_ex_RegT = 5'd0; id_ex_MemRead = 1'b0; branch_taken = 1'b0; md_start = 1'b0;
    endtask

    task automatic rstPulse();
        @(negedge clk); rst = 1'b1; idle();
        @(negedge clk); rst = 1'b0;
    endtask

    function automatic logic [4:0] outs();
        return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold};
    endfunction

    initial begin
        vecs[0]  = '{5'd1,  5'd2, 1'b1, 5'd3,  1'b1, 1'b0, 5'b11000};
        vecs[1]  = '{5'd8,  5'd2, 1'b0, 5'd8,  1'b1, 1'b0, 5'b00010};
        vecs[2]  = '{5'd1,  5'd8, 1'b0, 5'd8,  1'b1, 1'b0, 5'b11000};
        vecs[3]  = '{5'd1,  5'd8, 1'b1, 5'd8,  1'b1, 1'b0, 5'b00010};
        vecs[4]  = '{5'd0,  5'd3, 1'b0, 5'd0,  1'b1, 1'b0, 5'b11000};
        vecs[5]  = '{5'd4,  5'd0, 1'b1, 5'd0,  1'b1, 1'b0, 5'b11000};
        vecs[6]  = '{5'd8,  5'd8, 1'b1, 5'd8,  1'b0, 1'b0, 5'b11000};
        vecs[7]  = '{5'd1,  5'd2, 1'b1, 5'd3,  1'b0, 1'b1, 5'b11100};
        vecs[8]  = '{5'd8,  5'd2, 1'b1, 5'd8,  1'b1, 1'b1, 5'b00010};
        vecs[9]  = '{5'd5,  5'd6, 1'b1, 5'd7,  1'b1, 1'b1, 5'b11100};
        vecs[10] = '{5'd31, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 5'b00010};

        rst = 1'b1; idle();
        repeat (2) @(negedge clk);
        #1;
        chk("reset outs", {27'd0, outs()}, 32'b00110);
        chk("reset done", {31'd0, md_done}, 32'd0);
        chk("reset cnt", {28'd0, stall_cycles}, 32'd0);

        // Reset while MD_BUSY with md_cnt=2
        @(negedge clk); rst = 1'b0; md_start = 1'b1;
        #1 chk("md enter hold", {31'd0, EX_Hold}, 32'd1);
        @(negedge clk); md_start = 1'b0;
        #1 chk("md busy hold", {31'd0, EX_Hold}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rst = 1'b1;
            #1;
            chk("midmd rst outs", {27'd0, outs()}, 32'b00110);
            chk("midmd rst done", {31'd0, md_done}, 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        chk("post rst outs", {27'd0, outs()}, 32'b11000);
        chk("post rst done", {31'd0, md_done}, 32'd0);
        chk("post rst cnt", {28'd0, stall_cycles}, 32'd0);
        @(negedge clk);
        #1 chk("post rst run2", {26'd0, md_done, outs()}, 32'b011000);

        // RUN-state vector table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if_id_RegS = vecs[i].rs; if_id_RegT = vecs[i].rt; if_id_UsesT = vecs[i].usesT;
            id_ex_RegT = vecs[i].exRt; id_ex_MemRead = vecs[i].memRd; branch_taken = vecs[i].br;
            #1;
            chk($sformatf("vec%0d outs", i), {27'd0, outs()}, {27'd0, vecs[i].exp});
            chk($sformatf("vec%0d done", i), {31'd0, md_done}, 32'd0);
        end

        // Load-use: one stall cycle, then release
        rstPulse();
        id_ex_MemRead = 1'b1; id_ex_RegT = 5'd8; if_id_RegS = 5'd8;
        #1 chk("lu stall", {27'd0, outs()}, 32'b00010);
        @(negedge clk); id_ex_MemRead = 1'b0;
        #1;
        chk("lu release", {31'd0, PCWrite}, 32'd1);
        chk("lu cnt", {28'd0, stall_cycles}, 32'd1);

        // load_use beats branch; branch resolves the following cycle
        rstPulse();
        id_ex_MemRead = 1'b1; id_ex_RegT = 5'd8; if_id_RegS = 5'd8; branch_taken = 1'b1;
        #1 chk("prio stall", {27'd0, outs()}, 32'b00010);
        @(negedge clk); id_ex_MemRead = 1'b0;
        #1 chk("prio branch", {27'd0, outs()}, 32'b11100);

        // Single MULT/DIV
        rstPulse();
        md_start = 1'b1;
        #1 chk("md c1", {26'd0, md_done, outs()}, 32'b000001);
        @(negedge clk); md_start = 1'b0;
        #1 chk("md c2", {26'd0, md_done, outs()}, 32'b000001);
        @(negedge clk);
        #1 chk("md c3", {26'd0, md_done, outs()}, 32'b000001);
        @(negedge clk);
        #1 chk("md c4", {26'd0, md_done, outs()}, 32'b100000);
        @(negedge clk);
        #1;
        chk("md c5", {26'd0, md_done, outs()}, 32'b011000);
        chk("md cnt", {28'd0, stall_cycles}, 32'd4);

        // Back-to-back MULT/DIV
        rstPulse();
        md_start = 1'b1; doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("b2b c%0d pc", i + 1), {31'd0, PCWrite}, 32'd0);
            chk($sformatf("b2b c%0d done", i + 1), {31'd0, md_done}, {31'd0, (i % 4) == 3});
            doneCnt += int'(md_done);
        end
        @(negedge clk); md_start = 1'b0;
        #1;
        chk("b2b run", {31'd0, PCWrite}, 32'd1);
        chk("b2b pulses", doneCnt, 32'd2);
        chk("b2b cnt", {28'd0, stall_cycles}, 32'd8);

        // Saturation at 2^CNT_W-1 after 20 stall cycles
        rstPulse();
        md_start = 1'b1;
        repeat (14) @(negedge clk);
        #1 chk("sat 14", {28'd0, stall_cycles}, 32'd14);
        @(negedge clk);
        #1 chk("sat 15", {28'd0, stall_cycles}, 32'd15);
        repeat (5) @(negedge clk);
        #1 chk("sat 20", {28'd0, stall_cycles}, 32'd15);
        md_start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core; sits beside the forwarding unit.
- Handles the hazards that forwarding cannot resolve:
  - load-use: one-cycle stall plus bubble;
  - taken branch/jump resolved in ID: IF/ID flush;
  - multi-cycle MULT/DIV in EX: counted freeze of IF, ID and EX.
- Drives pipeline-register write enables and bubble/flush controls, and keeps a saturating stall-cycle counter for performance reporting.

Parameters:
- MD_LATENCY, 4, total EX-stage cycles of a MULT/DIV (legal 2..15).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_id_RegS  in  5  rs field of the instruction in ID.
- if_id_RegT  in  5  rt field of the instruction in ID.
- if_id_UsesT  in  1  instruction in ID reads rt (R-type, beq/bne, sw).
- id_ex_RegT  in  5  destination rt of the instruction in EX.
- id_ex_MemRead  in  1  instruction in EX is a load.
- branch_taken  in  1  ID-stage branch/jump resolved taken this cycle.
- md_start  in  1  MULT/DIV present in EX this cycle.
- PCWrite  out  1  PC register enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  load NOP into IF/ID at next edge.
- ID_EX_Bubble  out  1  load control-zero into ID/EX at next edge.
- EX_Hold  out  1  ID/EX and EX/MEM hold; MEM/WB receives bubble.
- md_done  out  1  one-cycle pulse on the final MULT/DIV cycle.
- stall_cycles  out  CNT_W  saturating count of cycles with PCWrite=0.

Behaviour:
- State register with two states, RUN and MD_BUSY. Down-counter md_cnt is 4 bits wide.
- All control outputs are combinational from state, md_cnt and inputs. stall_cycles is registered.

Reset:
- While rst=1: state<=RUN, md_cnt<=0, stall_cycles<=0.
- Outputs while rst=1: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, EX_Hold=0, md_done=0.
- Reset is honoured in any state, including mid MULT/DIV. The operation is abandoned and no md_done is issued.

Hazard conditions:
- load_use = id_ex_MemRead && id_ex_RegT!=0 && (id_ex_RegT==if_id_RegS || (if_id_UsesT && id_ex_RegT==if_id_RegT)).

RUN outputs, in priority order:
1. md_start=1: next state MD_BUSY, md_cnt<=MD_LATENCY-2. Outputs: PCWrite=0, IF_ID_Write=0, EX_Hold=1, ID_EX_Bubble=0, IF_ID_Flush=0. load_use and branch_taken are ignored this cycle and re-evaluated later, because their inputs are frozen.
2. load_use=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0. branch_taken is ignored, since it depends on a stale operand; the branch re-resolves next cycle. Exactly one stall cycle results, because the bubble clears id_ex_MemRead.
3. branch_taken=1: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=0.
4. Otherwise: PCWrite=1, IF_ID_Write=1, all others 0.

MD_BUSY:
- Outputs: PCWrite=0, IF_ID_Write=0, EX_Hold=1, ID_EX_Bubble=0, IF_ID_Flush=0. md_start, load_use and branch_taken are ignored.
- md_cnt!=0: md_cnt decrements each cycle.
- md_cnt==0: md_done=1, EX_Hold=0, PCWrite=0, IF_ID_Write=0. Next state RUN.
- Total stalled cycles per MULT/DIV = MD_LATENCY. On the first RUN cycle afterwards the MULT/DIV leaves EX.
- Back-to-back: if the next instruction in EX is also MULT/DIV, md_start re-asserts in RUN and re-enters MD_BUSY. There is no gap requirement.

Counter:
- stall_cycles increments on every edge where rst=0 and PCWrite=0.
- It saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Reset: hold rst=1 for 3 cycles in MD_BUSY (md_cnt=2) -> outputs at reset values throughout; first cycle after release is RUN with PCWrite=1; stall_cycles=0; no md_done.
- Load-use: id_ex_MemRead=1, id_ex_RegT=8, if_id_RegS=8 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle (MemRead=0) PCWrite=1; stall_cycles=1.
- Load-use on rt: rt=8 with if_id_UsesT=0 -> no stall. Same with UsesT=1 -> stall. id_ex_RegT=0 -> never stalls.
- Priority: load_use=1 and branch_taken=1 together -> IF_ID_Flush=0 and stall. Following cycle branch_taken=1 with no hazard -> IF_ID_Flush=1, PCWrite=1.
- MULT/DIV: md_start=1 with MD_LATENCY=4 -> EX_Hold=1 for cycles 1-3, md_done=1 in cycle 4, PCWrite=0 for all 4 cycles, RUN in cycle 5, stall_cycles=4. Back-to-back md_start -> 8 stall cycles, two md_done pulses.
- Saturation: CNT_W=4 with 20 stall cycles -> stall_cycles stops at 15.
